// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder: one CW-bit chunk per stage, valid/ready handshake on both ends.
// Optional macro PIPE_ADDER_SUB_EN enables subtraction via sub and signed overflow reporting.
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  logic [STAGES-1:0][WIDTH-1:0] aSkew_q, bSkew_q, sum_q, sum_d;
  logic [STAGES-1:0]            carry_q, carry_d, valid_q;
  logic [STAGES-1:0][WIDTH-1:0] aUp, bUp, sUp;
  logic [STAGES-1:0]            cUp, vUp, ready;
  logic [WIDTH-1:0]             bEff;
  logic                         cinEff;
  logic [CW:0]                  chunk;
  logic                         allFull;

`ifdef PIPE_ADDER_SUB_EN
  // Subtraction folds into operand B and the carry in before stage 0.
  assign bEff   = sub ? ~b : b;
  assign cinEff = sub ? 1'b1 : cin;
`else
  logic unusedSub;
  assign unusedSub = sub;
  assign bEff      = b;
  assign cinEff    = cin;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : gUp
    if (k == 0) begin : gFirst
      assign aUp[k] = a;
      assign bUp[k] = bEff;
      assign sUp[k] = '0;
      assign cUp[k] = cinEff;
      assign vUp[k] = in_valid;
    end else begin : gRest
      assign aUp[k] = aSkew_q[k-1];
      assign bUp[k] = bSkew_q[k-1];
      assign sUp[k] = sum_q[k-1];
      assign cUp[k] = carry_q[k-1];
      assign vUp[k] = valid_q[k-1];
    end
  end

  always_comb begin
    sum_d   = '0;
    carry_d = '0;
    chunk   = '0;
    for (int k = 0; k < STAGES; k++) begin
      chunk = {1'b0, aUp[k][k*CW +: CW]} + {1'b0, bUp[k][k*CW +: CW]} + {{CW{1'b0}}, cUp[k]};
      sum_d[k] = sUp[k];
      sum_d[k][k*CW +: CW] = chunk[CW-1:0];
      carry_d[k] = chunk[CW];
    end
  end

  // A stage can take new data unless it and every stage after it are full with the output stalled.
  always_comb begin
    ready   = '0;
    allFull = 1'b1;
    for (int k = 0; k < STAGES; k++) begin
      allFull = 1'b1;
      for (int j = k; j < STAGES; j++) allFull = allFull & valid_q[j];
      ready[k] = out_ready | ~allFull;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      carry_q <= '0;
      aSkew_q <= '0;
      bSkew_q <= '0;
      sum_q   <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (ready[k]) begin
          valid_q[k] <= vUp[k];
          if (vUp[k]) begin
            aSkew_q[k] <= aUp[k];
            bSkew_q[k] <= bUp[k];
            sum_q[k]   <= sum_d[k];
            carry_q[k] <= carry_d[k];
          end
        end
      end
    end
  end

  // Operand bits already consumed upstream are never read again; synthesis prunes them.
  logic unusedBits;
  assign unusedBits = ^{aSkew_q, bSkew_q, sum_q};

  assign in_ready  = ready[0];
  assign out_valid = valid_q[LAST];
  assign sum       = sum_q[LAST];
  assign carry_out = carry_q[LAST];

`ifdef PIPE_ADDER_SUB_EN
  assign overflow = (aSkew_q[LAST][WIDTH-1] == bSkew_q[LAST][WIDTH-1]) &&
                    (sum_q[LAST][WIDTH-1] != aSkew_q[LAST][WIDTH-1]);
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined ripple-carry adder with valid/ready handshakes on both sides. Operands are split into `STAGES` equal chunks. Each pipeline stage adds one chunk and registers the carry into the next stage, which sustains one result per clock at wide `WIDTH`. It is the general-purpose adder for the multiplier datapath's partial-product accumulation, replacing fixed-width combinational adders where timing closure needs registered carries.

## Interface
- `WIDTH`, 16: operand and sum width in bits; must be a multiple of `STAGES`.
- `STAGES`, 4: number of pipeline stages, ≥1. Chunk width `CW = WIDTH/STAGES`.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operands presented.
- `in_ready`  out  1  block accepts operands this cycle.
- `a`  in  WIDTH  operand A, unsigned or two's complement.
- `b`  in  WIDTH  operand B.
- `cin`  in  1  carry into bit 0.
- `sub`  in  1  subtract select; only functional with `PIPE_ADDER_SUB_EN`.
- `out_valid`  out  1  result held on outputs.
- `out_ready`  in  1  downstream takes result this cycle.
- `sum`  out  WIDTH  result.
- `carry_out`  out  1  carry out of bit WIDTH-1.
- `overflow`  out  1  signed overflow; 0 without `PIPE_ADDER_SUB_EN`.

## Operation
- Transfer on input when `in_valid && in_ready`; on output when `out_valid && out_ready`.
- Arithmetic: `{carry_out,sum} = a + b + cin`, computed modulo 2^(WIDTH+1). No saturation.
- Stage k (0..STAGES-1) adds chunk k of `a` and `b` plus the carry registered by stage k-1. Stage 0 uses `cin` as its carry in.
- Unprocessed upper operand chunks ride along in skew registers. Completed lower sum chunks ride along in deskew registers. The output stage therefore presents a coherent word.
- Each stage has a valid bit. Stage ready is `ready[k] = !valid[k] || ready[k+1]`, with `ready[STAGES] = out_ready`.
- `in_ready = ready[0]`, which is combinational from `out_ready` through the valid bits. Bubbles collapse: a stage accepts whenever it is empty, even if downstream is stalled.
- Results leave in acceptance order. There is no loss and no duplication.
- Reset: all valid bits and data registers are cleared.
  - After reset: `out_valid=0`, `sum=0`, `carry_out=0`, `overflow=0`.
  - `in_ready=1` as soon as `rst` deasserts.
- Reset mid-operation: in-flight transactions are discarded; no result for them ever appears.
- `in_valid` while the pipeline is full and `out_ready=0`: `in_ready=0`; operands are not captured.
- Full pipeline with `out_ready=1`: accept and retire occur in the same cycle, so throughput stays at 1 per cycle.

## Timing
- Latency is exactly `STAGES` cycles from the accepting edge to `out_valid=1`, provided no stall occurs.
- Throughput is one result per cycle with `out_ready` held high.
- While `out_valid && !out_ready`: `sum`, `carry_out` and `overflow` are held stable.
- Capacity is `STAGES` transactions.
- `STAGES=1`: registered combinational add; latency 1 cycle.
- Critical path is one `CW`-bit ripple plus the carry register.

## Configuration
- `PIPE_ADDER_SUB_EN` defined:
  - `sub=1` computes `a + ~b + 1`, ignoring `cin`. `carry_out=1` means no borrow.
  - `sub=0` is a normal add.
  - `sub` travels down the pipeline with its operands.
  - `overflow = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB])` in both modes, where `b_eff` is `~b` when subtracting and `b` otherwise.
- Undefined: the `sub` port is present but ignored (no registers), and `overflow` is tied 0.

## Test plan
All scenarios use `WIDTH=16`, `STAGES=4`.
- Reset: assert `rst` asynchronously mid-cycle -> `out_valid=0`, `sum=0x0000`, `carry_out=0` immediately; `in_ready=1` after release.
- Full carry ripple: `a=0xFFFF`, `b=0x0001`, `cin=0` -> `sum=0x0000`, `carry_out=1`, with `out_valid` rising exactly 4 cycles after acceptance. Also `a=0x7FFF`, `b=0`, `cin=1` -> `sum=0x8000`, `carry_out=0`.
- Streaming: 8 back-to-back random pairs with `out_ready=1` -> 8 correct results on 8 consecutive cycles, in order, starting cycle 4.
- Backpressure: `out_ready=0` while continuously driving `in_valid` -> exactly 4 accepted, then `in_ready=0`, output held stable. Raise `out_ready` -> all results in order with no duplicates, and acceptance resumes the same cycle.
- Subtract (macro defined):
  - `sub=1`, `a=0x8000`, `b=0x0001` -> `sum=0x7FFF`, `carry_out=1`, `overflow=1`.
  - `a=0x0000`, `b=0x0001` -> `sum=0xFFFF`, `carry_out=0`, `overflow=0`.
  - Macro undefined: `sub=1`, `a=0x8000`, `b=0x0001` -> `sum=0x8001`, `overflow=0`.
- Reset mid-operation: 3 transactions in flight, pulse `rst` -> no `out_valid` for them. A new transaction issued afterwards returns correctly after 4 cycles.
